// File: rtl/dmx_slot_read_arbiter.sv
// Round-robin arbiter sharing the DMX frame-buffer EBR read port; masks reads past the last received slot.
// Optional build macro DMX_ARB_PRIORITY_EN gives requester 0 fixed top priority.
module dmx_slot_read_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int DMX_SLOTS = 513
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_oor,
  output logic                    busy,
  input  logic                    frame_done,
  input  logic [9:0]              n_of_data,
  output logic [9:0]              slot_count,
  output logic [ADDR_W-1:0]       ebr_addr,
  input  logic [DATA_W-1:0]       ebr_q
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CMP_W = (ADDR_W > 10) ? ADDR_W : 10;
  localparam logic [9:0] SLOT_MAX = 10'(DMX_SLOTS);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_r;
  logic [IDX_W-1:0]    rr_ptr_r;
  logic [IDX_W-1:0]    sel_r;
  logic                oor_r;
  logic [N_REQ-1:0]    gnt_r;
  logic [N_REQ-1:0]    rd_valid_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                rd_oor_r;
  logic                busy_r;
  logic [ADDR_W-1:0]   ebr_addr_r;
  logic [9:0]          slot_count_r;

  logic                pick_vld_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [ADDR_W-1:0]   pick_addr_s;
  logic                pick_oor_s;
  int                  cand_s;

  // Arbitration: first requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = {IDX_W{1'b0}};
    cand_s     = 0;
`ifdef DMX_ARB_PRIORITY_EN
    if (req[0]) begin
      pick_vld_s = 1'b1;
      pick_idx_s = {IDX_W{1'b0}};
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        cand_s = int'(rr_ptr_r) + k;
        cand_s = (cand_s >= N_REQ) ? cand_s - N_REQ : cand_s;
        if (!pick_vld_s && (cand_s != 0) && req[cand_s]) begin
          pick_vld_s = 1'b1;
          pick_idx_s = IDX_W'(cand_s);
        end else begin
          pick_vld_s = pick_vld_s;
        end
      end
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = int'(rr_ptr_r) + k;
      cand_s = (cand_s >= N_REQ) ? cand_s - N_REQ : cand_s;
      if (!pick_vld_s && req[cand_s]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = IDX_W'(cand_s);
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
`endif
    pick_addr_s = req_addr[pick_idx_s*ADDR_W +: ADDR_W];
    pick_oor_s  = (CMP_W'(pick_addr_s) >= CMP_W'(slot_count_r));
  end

  // Access sequencer ARB -> WAIT -> DATA with registered grant/data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_ARB;
      rr_ptr_r   <= {IDX_W{1'b0}};
      sel_r      <= {IDX_W{1'b0}};
      oor_r      <= 1'b0;
      gnt_r      <= {N_REQ{1'b0}};
      rd_valid_r <= {N_REQ{1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
      rd_oor_r   <= 1'b0;
      busy_r     <= 1'b0;
      ebr_addr_r <= {ADDR_W{1'b0}};
    end else begin
      gnt_r      <= {N_REQ{1'b0}};
      rd_valid_r <= {N_REQ{1'b0}};
      case (state_r)
        ST_ARB: begin
          if (pick_vld_s) begin
            sel_r      <= pick_idx_s;
            oor_r      <= pick_oor_s;
            ebr_addr_r <= pick_addr_s;
            gnt_r      <= ONE_HOT0 << pick_idx_s;
            busy_r     <= 1'b1;
            state_r    <= ST_WAIT;
          end else begin
            state_r    <= ST_ARB;
          end
        end
        ST_WAIT: begin
          state_r <= ST_DATA;
        end
        ST_DATA: begin
          rd_data_r  <= oor_r ? {DATA_W{1'b0}} : ebr_q;
          rd_oor_r   <= oor_r;
          rd_valid_r <= ONE_HOT0 << sel_r;
          busy_r     <= 1'b0;
          state_r    <= ST_ARB;
`ifdef DMX_ARB_PRIORITY_EN
          if (sel_r != {IDX_W{1'b0}}) begin
            rr_ptr_r <= (sel_r == IDX_LAST) ? {IDX_W{1'b0}} : sel_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end else begin
            rr_ptr_r <= rr_ptr_r;
          end
`else
          rr_ptr_r <= (sel_r == IDX_LAST) ? {IDX_W{1'b0}} : sel_r + {{(IDX_W-1){1'b0}}, 1'b1};
`endif
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_ARB;
        end
      endcase
    end
  end

  // Latched valid-slot count, clamped to the buffer depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_count_r <= 10'd0;
    end else if (frame_done) begin
      slot_count_r <= (n_of_data > SLOT_MAX) ? SLOT_MAX : n_of_data;
    end else begin
      slot_count_r <= slot_count_r;
    end
  end

  assign gnt        = gnt_r;
  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_data_r;
  assign rd_oor     = rd_oor_r;
  assign busy       = busy_r;
  assign slot_count = slot_count_r;
  assign ebr_addr   = ebr_addr_r;

endmodule

// File: tb/tb_dmx_slot_read_arbiter.sv
// Directed self-checking bench for dmx_slot_read_arbiter with a synchronous-read EBR model.
module tb_dmx_slot_read_arbiter;
  localparam int N_REQ  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_oor;
  logic                    busy;
  logic                    frame_done;
  logic [9:0]              n_of_data;
  logic [9:0]              slot_count;
  logic [ADDR_W-1:0]       ebr_addr;
  logic [DATA_W-1:0]       ebr_q;

  logic [7:0] mem [0:1023];
  int n_tests = 0;
  int n_fail  = 0;

  dmx_slot_read_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DMX_SLOTS(513)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_oor(rd_oor), .busy(busy),
    .frame_done(frame_done), .n_of_data(n_of_data), .slot_count(slot_count),
    .ebr_addr(ebr_addr), .ebr_q(ebr_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ebr_q <= mem[ebr_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic frame(input logic [9:0] n, input logic [9:0] exp_cnt);
    frame_done = 1'b1;
    n_of_data  = n;
    step();
    frame_done = 1'b0;
    check_eq("slot_count", 32'(slot_count), 32'(exp_cnt));
  endtask

  // Single read; optionally a frame_done on the same cycle as the ARB decision.
  task automatic do_read(input int idx, input logic [9:0] addr, input logic [7:0] exp_d,
                         input logic exp_oor, input bit fd, input logic [9:0] fd_n);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    req_addr[idx*ADDR_W +: ADDR_W] = addr;
    req = oh;
    if (fd) begin
      frame_done = 1'b1;
      n_of_data  = fd_n;
    end
    step();
    req = 4'b0000;
    frame_done = 1'b0;
    check_eq("gnt_t1", 32'(gnt), 32'(oh));
    check_eq("busy_t1", 32'(busy), 32'd1);
    check_eq("ebr_addr_t1", 32'(ebr_addr), 32'(addr));
    step();
    check_eq("gnt_t2", 32'(gnt), 32'd0);
    check_eq("rd_valid_t2", 32'(rd_valid), 32'd0);
    step();
    check_eq("rd_valid_t3", 32'(rd_valid), 32'(oh));
    check_eq("rd_data_t3", 32'(rd_data), 32'(exp_d));
    check_eq("rd_oor_t3", 32'(rd_oor), 32'(exp_oor));
    check_eq("busy_t3", 32'(busy), 32'd0);
  endtask

  task automatic check_idle_reset();
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_rd_oor", 32'(rd_oor), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ebr_addr", 32'(ebr_addr), 32'd0);
    check_eq("rst_slot_count", 32'(slot_count), 32'd0);
  endtask

  initial begin
    int order [5];
    int order2 [3];
    logic [9:0] addrs [4];
    int exp_g;
    int exp_v;

    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 7 + 3) & 255);
    mem[199] = 8'hA5;
    rst_n = 1'b0;
    req = 4'b0000;
    req_addr = '0;
    frame_done = 1'b0;
    n_of_data = 10'd0;

    // Reset state
    step(); step(); step();
    check_idle_reset();
    rst_n = 1'b1;
    step();

    // Read before any frame is out of range
    do_read(2, 10'd5, 8'h00, 1'b1, 1'b0, 10'd0);

    // Frame of 200 bytes: last valid slot 199, slot 200 masked
    frame(10'd200, 10'd200);
    do_read(1, 10'd199, 8'hA5, 1'b0, 1'b0, 10'd0);
    do_read(1, 10'd200, 8'h00, 1'b1, 1'b0, 10'd0);
    do_read(3, 10'd0, mem[0], 1'b0, 1'b0, 10'd0);

    // All four requesting; rr_ptr is 0 after the grant to requester 3
`ifdef DMX_ARB_PRIORITY_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      addrs[i] = 10'(10 * (i + 1));
      req_addr[i*ADDR_W +: ADDR_W] = addrs[i];
    end
    req = 4'b1111;
    for (int k = 1; k <= 15; k++) begin
      step();
      exp_g = ((k % 3) == 1) ? (1 << order[(k-1)/3]) : 0;
      exp_v = ((k % 3) == 0) ? (1 << order[k/3-1]) : 0;
      check_eq("all_gnt", 32'(gnt), 32'(exp_g));
      check_eq("all_rd_valid", 32'(rd_valid), 32'(exp_v));
      if ((k % 3) == 0) begin
        check_eq("all_rd_data", 32'(rd_data), 32'(mem[addrs[order[k/3-1]]]));
      end
    end
    req = 4'b0000;

    // Requester 0 released: 1,2,3 rotate
    order2 = '{1, 2, 3};
    req = 4'b1110;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_g = ((k % 3) == 1) ? (1 << order2[(k-1)/3]) : 0;
      check_eq("rot_gnt", 32'(gnt), 32'(exp_g));
      if ((k % 3) == 0) begin
        check_eq("rot_rd_valid", 32'(rd_valid), 32'(1 << order2[k/3-1]));
        check_eq("rot_rd_data", 32'(rd_data), 32'(mem[addrs[order2[k/3-1]]]));
      end
    end
    req = 4'b0000;

    // Clamp to buffer depth, then same-cycle frame_done uses the old count
    frame(10'd600, 10'd513);
    frame(10'd100, 10'd100);
    do_read(2, 10'd300, 8'h00, 1'b1, 1'b1, 10'd600);
    check_eq("slot_count_after_fd", 32'(slot_count), 32'd513);
    do_read(2, 10'd300, mem[300], 1'b0, 1'b0, 10'd0);

    // Reset during WAIT aborts the access
    req_addr[1*ADDR_W +: ADDR_W] = 10'd50;
    req = 4'b0010;
    step();
    check_eq("pre_rst_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    rst_n = 1'b0;
    #1;
    check_idle_reset();
    step();
    check_eq("rst_hold_rd_valid", 32'(rd_valid), 32'd0);
    step();
    check_eq("rst_hold_rd_valid2", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_rd_valid", 32'(rd_valid), 32'd0);
    frame(10'd200, 10'd200);
    do_read(0, 10'd50, mem[50], 1'b0, 1'b0, 10'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
